// File: rtl/pong_render_pkg.sv
// rtl/pong_render_pkg.sv - sequencer state encoding and constants shared with ball_render
package pong_render_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_BLACK = 3'd0,
    ST_IDLE       = 3'd1,
    ST_CLEAR      = 3'd2,
    ST_DRAW       = 3'd3,
    ST_BLACK      = 3'd4,
    ST_HOLD       = 3'd5
  } seq_state_t;

  localparam int HOLD_FRAMES_DEFAULT = 15;
  localparam int TIMEOUT_DEFAULT     = 131071;
  localparam int SCREEN_PIXELS       = 76800;

  // States in which the renderer is busy and a done_* is awaited
  function automatic logic is_phase(input seq_state_t s);
    return (s == ST_BOOT_BLACK) || (s == ST_CLEAR) || (s == ST_DRAW) || (s == ST_BLACK);
  endfunction

endpackage

// File: rtl/render_watchdog.sv
// rtl/render_watchdog.sv - per-phase cycle counter that expires after TIMEOUT cycles
module render_watchdog #(
  parameter int TIMEOUT = 131071
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds (cycles spent in phase - 1), so expiry lands on the TIMEOUT-th cycle
  assign expired = run && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - frame draw handshake initiator for ball_render; SEQ_TIMEOUT_EN adds a phase watchdog
module render_sequencer
  import pong_render_pkg::*;
#(
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic frameTick,
  input  logic lhs_scored,
  input  logic rhs_scored,
  input  logic done_clearOld,
  input  logic done_drawNew,
  input  logic done_blackScreen,
  output logic clearOld_pulse,
  output logic drawNew_pulse,
  output logic blackScreen_pulse,
  output logic plot,
  output logic physics_en,
  output logic round_start,
  output logic frame_drop,
  output logic seq_error
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  seq_state_t    state, state_d;
  logic          fresh;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          score_pend;
  logic          timed_out;
  logic          advance;

  assign advance   = frameTick && enable;
  assign hold_last = (hold_cnt == HW'(HOLD_FRAMES - 1));

  // fresh marks the entry cycle of a state; done_* is ignored while it is set
  always_comb begin
    state_d = state;
    case (state)
      ST_BOOT_BLACK, ST_BLACK: begin
        if ((done_blackScreen && !fresh) || timed_out) state_d = ST_HOLD;
      end
      ST_IDLE: begin
        if (advance) state_d = (lhs_scored || rhs_scored || score_pend) ? ST_BLACK : ST_CLEAR;
      end
      ST_CLEAR: begin
        if (done_clearOld && !fresh) state_d = ST_DRAW;
        else if (timed_out)          state_d = ST_BLACK;
      end
      ST_DRAW: begin
        if (done_drawNew && !fresh) state_d = ST_IDLE;
        else if (timed_out)         state_d = ST_BLACK;
      end
      ST_HOLD: begin
        if (advance && hold_last) state_d = ST_IDLE;
      end
      default: state_d = ST_BOOT_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_BOOT_BLACK;
      fresh <= 1'b1;
    end else begin
      state <= state_d;
      fresh <= (state_d != state);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt    <= '0;
      score_pend  <= 1'b0;
      frame_drop  <= 1'b0;
      round_start <= 1'b0;
    end else begin
      round_start <= (state == ST_HOLD) && (state_d == ST_IDLE);
      if (state != ST_HOLD) begin
        hold_cnt <= '0;
      end else if (advance && !hold_last) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if ((state == ST_IDLE) && (state_d == ST_BLACK)) begin
        score_pend <= 1'b0;
      end else if ((state != ST_IDLE) && (lhs_scored || rhs_scored)) begin
        score_pend <= 1'b1;
      end
      // A tick that cannot start a frame is dropped, never queued
      if (frameTick && (state != ST_IDLE) && (state != ST_HOLD)) begin
        frame_drop <= 1'b1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic in_phase;
  logic seq_error_q;

  assign in_phase = is_phase(state);

  render_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (!in_phase || (state_d != state)),
    .run    (in_phase),
    .expired(timed_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_error_q <= 1'b0;
    end else if (timed_out) begin
      seq_error_q <= 1'b1;
    end
  end

  assign seq_error = seq_error_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timed_out = 1'b0;
  assign seq_error = 1'b0;
`endif

  assign clearOld_pulse    = (state == ST_CLEAR);
  assign drawNew_pulse     = (state == ST_DRAW);
  assign blackScreen_pulse = (state == ST_BLACK) || (state == ST_BOOT_BLACK);
  assign plot              = clearOld_pulse || drawNew_pulse || blackScreen_pulse;
  assign physics_en        = (state == ST_IDLE);

endmodule

// File: tb/tb_render_sequencer.sv
// tb/tb_render_sequencer.sv - directed scenarios plus randomized run against a frame-level reference model
module tb_render_sequencer;

  localparam int HF = 15;
  localparam int TO_CYCLES = 100;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Expected output vectors: {clear, draw, black, plot, physics, round_start, frame_drop, seq_error}
  localparam logic [7:0] V_BLACK = 8'b0011_0000;
  localparam logic [7:0] V_IDLE  = 8'b0000_1000;
  localparam logic [7:0] V_CLEAR = 8'b1001_0000;
  localparam logic [7:0] V_DRAW  = 8'b0101_0000;
  localparam logic [7:0] V_HOLD  = 8'b0000_0000;
  localparam logic [7:0] V_RS    = 8'b0000_0100;
  localparam logic [7:0] V_DROP  = 8'b0000_0010;
  localparam logic [7:0] V_ERR   = 8'b0000_0001;

  localparam int P_BOOT = 0, P_IDLE = 1, P_CLEAR = 2, P_DRAW = 3, P_BLACK = 4, P_HOLD = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  logic frameTick = 1'b0;
  logic lhs_scored = 1'b0, rhs_scored = 1'b0;
  logic done_clearOld = 1'b0, done_drawNew = 1'b0, done_blackScreen = 1'b0;
  logic clearOld_pulse, drawNew_pulse, blackScreen_pulse, plot;
  logic physics_en, round_start, frame_drop, seq_error;
  logic [7:0] outs;
  logic [7:0] exp_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign outs = {clearOld_pulse, drawNew_pulse, blackScreen_pulse, plot,
                 physics_en, round_start, frame_drop, seq_error};

  render_sequencer #(
    .HOLD_FRAMES(HF),
    .TIMEOUT    (TO_CYCLES)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .frameTick        (frameTick),
    .lhs_scored       (lhs_scored),
    .rhs_scored       (rhs_scored),
    .done_clearOld    (done_clearOld),
    .done_drawNew     (done_drawNew),
    .done_blackScreen (done_blackScreen),
    .clearOld_pulse   (clearOld_pulse),
    .drawNew_pulse    (drawNew_pulse),
    .blackScreen_pulse(blackScreen_pulse),
    .plot             (plot),
    .physics_en       (physics_en),
    .round_start      (round_start),
    .frame_drop       (frame_drop),
    .seq_error        (seq_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frameTick = 1'b1; step(); frameTick = 1'b0;
  endtask

  task automatic pulse_dc();
    done_clearOld = 1'b1; step(); done_clearOld = 1'b0;
  endtask

  task automatic pulse_dd();
    done_drawNew = 1'b1; step(); done_drawNew = 1'b0;
  endtask

  task automatic pulse_db();
    done_blackScreen = 1'b1; step(); done_blackScreen = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic boot_to_idle();
    repeat (4) step();
    pulse_db();
    repeat (HF) begin tick(); step(); end
  endtask

  function automatic logic [7:0] phase_vec(input int ph);
    case (ph)
      P_BOOT, P_BLACK: return V_BLACK;
      P_IDLE:          return V_IDLE;
      P_CLEAR:         return V_CLEAR;
      P_DRAW:          return V_DRAW;
      default:         return V_HOLD;
    endcase
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    checks++;
    if (outs !== V_BLACK) begin errors++; $display("FAIL reset_outputs got=%b want=%b", outs, V_BLACK); end
    resetn = 1'b1;
  endtask

  task automatic test_boot_hold();
    repeat (4) step();
    pulse_db();
    checks++;
    if (outs !== V_HOLD) begin errors++; $display("FAIL boot_to_hold got=%b want=%b", outs, V_HOLD); end
    repeat (HF - 1) begin tick(); step(); end
    checks++;
    if (outs !== V_HOLD) begin errors++; $display("FAIL hold_before_last got=%b want=%b", outs, V_HOLD); end
    tick();
    checks++;
    if (outs !== (V_IDLE | V_RS)) begin errors++; $display("FAIL round_start got=%b want=%b", outs, V_IDLE | V_RS); end
    step();
    checks++;
    if (outs !== V_IDLE) begin errors++; $display("FAIL round_start_once got=%b want=%b", outs, V_IDLE); end
  endtask

  task automatic test_frame();
    tick();
    checks++;
    if (outs !== V_CLEAR) begin errors++; $display("FAIL frame_clear got=%b want=%b", outs, V_CLEAR); end
    repeat (4) step();
    pulse_dc();
    checks++;
    if (outs !== V_DRAW) begin errors++; $display("FAIL frame_draw got=%b want=%b", outs, V_DRAW); end
    step();
    pulse_dd();
    checks++;
    if (outs !== V_IDLE) begin errors++; $display("FAIL frame_idle got=%b want=%b", outs, V_IDLE); end
  endtask

  task automatic test_score();
    tick(); step(); pulse_dc();
    lhs_scored = 1'b1; step(); step(); lhs_scored = 1'b0; step();
    pulse_dd();
    checks++;
    if (outs !== V_IDLE) begin errors++; $display("FAIL score_draw_done got=%b want=%b", outs, V_IDLE); end
    tick();
    checks++;
    if (outs !== V_BLACK) begin errors++; $display("FAIL score_pend_black got=%b want=%b", outs, V_BLACK); end
    step(); pulse_db();
    repeat (HF) begin tick(); step(); end
    tick();
    checks++;
    if (outs !== V_CLEAR) begin errors++; $display("FAIL score_pend_cleared got=%b want=%b", outs, V_CLEAR); end
    step(); pulse_dc(); step(); pulse_dd();
  endtask

  task automatic test_frame_drop();
    tick();
    checks++;
    if (outs !== V_CLEAR) begin errors++; $display("FAIL drop_clean got=%b want=%b", outs, V_CLEAR); end
    step(); tick();
    checks++;
    if (outs !== (V_CLEAR | V_DROP)) begin errors++; $display("FAIL drop_set got=%b want=%b", outs, V_CLEAR | V_DROP); end
    pulse_dc();
    checks++;
    if (outs !== (V_DRAW | V_DROP)) begin errors++; $display("FAIL drop_progress got=%b want=%b", outs, V_DRAW | V_DROP); end
    step();
    frameTick = 1'b1; done_drawNew = 1'b1; step(); frameTick = 1'b0; done_drawNew = 1'b0;
    step();
    checks++;
    if (outs !== (V_IDLE | V_DROP)) begin errors++; $display("FAIL tick_with_done got=%b want=%b", outs, V_IDLE | V_DROP); end
  endtask

  task automatic test_done_filter();
    do_reset(); boot_to_idle();
    tick(); pulse_dc();
    checks++;
    if (outs !== V_CLEAR) begin errors++; $display("FAIL entry_done_ignored got=%b want=%b", outs, V_CLEAR); end
    pulse_dd(); pulse_db();
    checks++;
    if (outs !== V_CLEAR) begin errors++; $display("FAIL foreign_done_ignored got=%b want=%b", outs, V_CLEAR); end
    enable = 1'b0;
    pulse_dc();
    checks++;
    if (outs !== V_DRAW) begin errors++; $display("FAIL phase_runs_disabled got=%b want=%b", outs, V_DRAW); end
    step(); pulse_dd(); tick(); step();
    checks++;
    if (outs !== V_IDLE) begin errors++; $display("FAIL idle_frozen got=%b want=%b", outs, V_IDLE); end
    enable = 1'b1;
    tick();
    resetn = 1'b0; #1;
    checks++;
    if (outs !== V_BLACK) begin errors++; $display("FAIL async_abort got=%b want=%b", outs, V_BLACK); end
    step(); resetn = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
    do_reset(); boot_to_idle();
    tick(); step(); pulse_dc();
    repeat (TO_CYCLES - 1) step();
    checks++;
    if (outs !== V_DRAW) begin errors++; $display("FAIL timeout_early got=%b want=%b", outs, V_DRAW); end
    step();
    checks++;
    if (outs !== (V_BLACK | V_ERR)) begin errors++; $display("FAIL timeout_fire got=%b want=%b", outs, V_BLACK | V_ERR); end
`endif
  endtask

  task automatic test_random();
    int ph, nph, age, hc;
    bit pend, drop, err, rs, to;
    bit ft, en, l, r, dc, dd, db;
    do_reset();
    ph = P_BOOT; age = 1; hc = 0; pend = 0; drop = 0; err = 0; rs = 0;
    for (int c = 0; c < 4000; c++) begin
      exp_v = phase_vec(ph) | {5'b0, rs, drop, err};
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d got=%b want=%b", c, outs, exp_v);
      end
      ft = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 7) != 0);
      l  = ($urandom_range(0, 79) == 0);
      r  = ($urandom_range(0, 79) == 0);
      dc = ($urandom_range(0, 3) == 0);
      dd = ($urandom_range(0, 3) == 0);
      db = ($urandom_range(0, 3) == 0);
      frameTick = ft; enable = en; lhs_scored = l; rhs_scored = r;
      done_clearOld = dc; done_drawNew = dd; done_blackScreen = db;
      nph = ph; rs = 0;
      to = TIMEOUT_ON && (age >= TO_CYCLES);
      if (ft && ph != P_IDLE && ph != P_HOLD) drop = 1;
      case (ph)
        P_BOOT, P_BLACK: begin
          if (db && age > 1) nph = P_HOLD;
          else if (to) begin nph = P_HOLD; err = 1; end
        end
        P_IDLE: if (ft && en) begin
          if (l || r || pend) begin nph = P_BLACK; pend = 0; end
          else nph = P_CLEAR;
        end
        P_CLEAR: begin
          if (dc && age > 1) nph = P_DRAW;
          else if (to) begin nph = P_BLACK; err = 1; end
        end
        P_DRAW: begin
          if (dd && age > 1) nph = P_IDLE;
          else if (to) begin nph = P_BLACK; err = 1; end
        end
        default: if (ft && en) begin
          if (hc == HF - 1) begin nph = P_IDLE; rs = 1; end
          else hc++;
        end
      endcase
      if (ph != P_IDLE && (l || r)) pend = 1;
      if (nph == P_HOLD && ph != P_HOLD) hc = 0;
      age = (nph != ph) ? 1 : age + 1;
      ph = nph;
      step();
    end
    frameTick = 0; enable = 1; lhs_scored = 0; rhs_scored = 0;
    done_clearOld = 0; done_drawNew = 0; done_blackScreen = 0;
  endtask

  initial begin
    test_reset();
    test_boot_hold();
    test_frame();
    test_score();
    test_frame_drop();
    test_done_filter();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
